// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier (binary32/binary64) using a radix-2 shift-add significand core.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_seq #(
    parameter int X = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [X-1:0] A,
    input  logic [X-1:0] B,
    output logic         busy,
    output logic [X-1:0] out,
    output logic         done,
    output logic         overflow_flag,
    output logic         underflow_flag,
    output logic         invalid_flag
);
    localparam int EB   = (X == 64) ? 11 : 8;
    localparam int MB   = (X == 64) ? 52 : 23;
    localparam int BIAS = (X == 64) ? 1023 : 127;
    localparam int S    = MB + 1;
    localparam int EW   = EB + 2;
    localparam int CW   = $clog2(S + 1);
    localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EB) - 1);
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E  = {EW{1'b0}};
`ifdef FP_MUL_ROUND_EN
    localparam logic RND_EN = 1'b1;
`else
    localparam logic RND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, NORM, ROUND} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [X-1:0]           out_q, out_d, spec_res_q, spec_res_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
    logic                   sign_q, sign_d, special_q, special_d, spec_inv_q, spec_inv_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [2*S-1:0]         mcand_q, mcand_d, prod_q, prod_d;
    logic [S-1:0]           mplier_q, mplier_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MB-1:0]          mant_q, mant_d;
    logic                   guard_q, guard_d, sticky_q, sticky_d;

    logic [EB-1:0]          exp_a, exp_b;
    logic [MB-1:0]          man_a, man_b;
    logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, in_sign;
    logic                   round_up;
    logic [MB:0]            mant_rnd;
    logic signed [EW-1:0]   exp_rnd;

    assign exp_a   = A[X-2:MB];
    assign exp_b   = B[X-2:MB];
    assign man_a   = A[MB-1:0];
    assign man_b   = B[MB-1:0];
    assign a_nan   = (&exp_a) & (|man_a);
    assign b_nan   = (&exp_b) & (|man_b);
    assign a_inf   = (&exp_a) & ~(|man_a);
    assign b_inf   = (&exp_b) & ~(|man_b);
    assign a_zero  = (exp_a == {EB{1'b0}});
    assign b_zero  = (exp_b == {EB{1'b0}});
    assign in_sign = A[X-1] ^ B[X-1];

    // Next-state and datapath logic for the IDLE/MUL/NORM/ROUND sequence.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        out_d      = out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inv_d      = inv_q;
        sign_d     = sign_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_inv_d = spec_inv_q;
        exp_d      = exp_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        mant_d     = mant_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        round_up   = 1'b0;
        mant_rnd   = {(MB+1){1'b0}};
        exp_rnd    = ZERO_E;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    inv_d      = 1'b0;
                    sign_d     = in_sign;
                    exp_d      = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E;
                    mcand_d    = {{S{1'b0}}, 1'b1, man_a};
                    mplier_d   = {1'b1, man_b};
                    prod_d     = {(2*S){1'b0}};
                    cnt_d      = {CW{1'b0}};
                    spec_inv_d = 1'b0;
                    // Special operands skip the datapath and retire through ROUND.
                    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                        special_d  = 1'b1;
                        spec_inv_d = 1'b1;
                        spec_res_d = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
                        state_d    = ROUND;
                    end else if (a_inf || b_inf) begin
                        special_d  = 1'b1;
                        spec_res_d = {in_sign, {EB{1'b1}}, {MB{1'b0}}};
                        state_d    = ROUND;
                    end else if (a_zero || b_zero) begin
                        special_d  = 1'b1;
                        spec_res_d = {in_sign, {(X-1){1'b0}}};
                        state_d    = ROUND;
                    end else begin
                        special_d  = 1'b0;
                        state_d    = MUL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end else begin
                    prod_d = prod_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(S - 1)) begin
                    state_d = NORM;
                end else begin
                    state_d = MUL;
                end
            end
            NORM: begin
                if (prod_q[2*S-1]) begin
                    exp_d    = exp_q + ONE_E;
                    mant_d   = prod_q[2*S-2:S];
                    guard_d  = prod_q[S-1];
                    sticky_d = |prod_q[S-2:0];
                end else begin
                    mant_d   = prod_q[2*S-3:S-1];
                    guard_d  = prod_q[S-2];
                    sticky_d = |prod_q[S-3:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (special_q) begin
                    out_d = spec_res_q;
                    inv_d = spec_inv_q;
                end else begin
                    round_up = RND_EN & guard_q & (sticky_q | mant_q[0]);
                    mant_rnd = {1'b0, mant_q} + {{MB{1'b0}}, round_up};
                    // An all-ones mantissa rounding up leaves zeros and bumps the exponent.
                    exp_rnd  = exp_q + $signed({{(EW-1){1'b0}}, mant_rnd[MB]});
                    if (exp_rnd >= EXP_MAX) begin
                        out_d = {sign_q, {EB{1'b1}}, {MB{1'b0}}};
                        ovf_d = 1'b1;
                    end else if (exp_rnd <= ZERO_E) begin
                        out_d = {sign_q, {(X-1){1'b0}}};
                        unf_d = 1'b1;
                    end else begin
                        out_d = {sign_q, exp_rnd[EB-1:0], mant_rnd[MB-1:0]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= {X{1'b0}};
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= {X{1'b0}};
            spec_inv_q <= 1'b0;
            exp_q      <= ZERO_E;
            mcand_q    <= {(2*S){1'b0}};
            prod_q     <= {(2*S){1'b0}};
            mplier_q   <= {S{1'b0}};
            cnt_q      <= {CW{1'b0}};
            mant_q     <= {MB{1'b0}};
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inv_q      <= inv_d;
            sign_q     <= sign_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            exp_q      <= exp_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            mant_q     <= mant_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign out            = out_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;
    assign invalid_flag   = inv_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed cases plus random operands against an exact-integer model,
// for both X=32 and X=64 instances.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, start64 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, out32;
    logic [63:0] a64 = '0, b64 = '0, out64;
    logic        busy32, done32, ovf32, unf32, inv32;
    logic        busy64, done64, ovf64, unf64, inv64;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fp_mul_seq #(.X(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .A(a32), .B(b32),
        .busy(busy32), .out(out32), .done(done32),
        .overflow_flag(ovf32), .underflow_flag(unf32), .invalid_flag(inv32));

    fp_mul_seq #(.X(64)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .A(a64), .B(b64),
        .busy(busy64), .out(out64), .done(done64),
        .overflow_flag(ovf64), .underflow_flag(unf64), .invalid_flag(inv64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exact reference: full integer product, then round (ties to even) and range-check.
    function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b, input bit w64,
                                    output logic [63:0] res, output logic [2:0] flg, output int lat);
        int nexp = w64 ? 11 : 8;
        int nman = w64 ? 52 : 23;
        int bias = w64 ? 1023 : 127;
        int emax = (1 << nexp) - 1;
        logic [63:0] mask = (64'd1 << nman) - 64'd1;
        logic [63:0] ea = (a >> nman) & 64'(emax);
        logic [63:0] eb = (b >> nman) & 64'(emax);
        logic [63:0] ma = a & mask;
        logic [63:0] mb = b & mask;
        logic        sgn = w64 ? (a[63] ^ b[63]) : (a[31] ^ b[31]);
        logic [63:0] sres = 64'(sgn) << (nexp + nman);
        logic [63:0] infv = sres | (64'(emax) << nman);
        bit nan_a = (ea == 64'(emax)) && (ma != 0);
        bit nan_b = (eb == 64'(emax)) && (mb != 0);
        bit inf_a = (ea == 64'(emax)) && (ma == 0);
        bit inf_b = (eb == 64'(emax)) && (mb == 0);
        bit zer_a = (ea == 0);
        bit zer_b = (eb == 0);
        logic [127:0] p, q, rem, half;
        int msb = 0, sh, e;
        flg = 3'b000;
        lat = 1;
        if (nan_a || nan_b || (inf_a && zer_b) || (zer_a && inf_b)) begin
            res = (64'(emax) << nman) | (64'd1 << (nman - 1));
            flg = 3'b001;
        end else if (inf_a || inf_b) begin
            res = infv;
        end else if (zer_a || zer_b) begin
            res = sres;
        end else begin
            lat = nman + 3;
            p = 128'(ma | (64'd1 << nman)) * 128'(mb | (64'd1 << nman));
            for (int i = 127; i >= 0; i--) begin
                if (p[i]) begin msb = i; break; end
            end
            sh   = msb - nman;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 128'd1 << (sh - 1);
`ifdef FP_MUL_ROUND_EN
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
`endif
            e = int'(ea) + int'(eb) - bias + (msb - 2 * nman);
            if ((q >> (nman + 1)) != 0) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                res = infv;
                flg = 3'b100;
            end else if (e <= 0) begin
                res = sres;
                flg = 3'b010;
            end else begin
                res = sres | (64'(e) << nman) | (64'(q) & mask);
            end
        end
    endfunction

    // One transaction; optionally pulses a stray start (other operands) pulse_at cycles after accept.
    task automatic run(input bit w64, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eo, input logic [2:0] ef, input int el,
                       input int pulse_at, input string tag);
        int lat = 0;
        bit got = 0;
        @(negedge clk);
        if (w64) begin a64 = a; b64 = b; start64 = 1'b1; end
        else begin a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1; end
        @(negedge clk);
        start32 = 1'b0;
        start64 = 1'b0;
        chk({tag, "_busy_acc"}, 64'(w64 ? busy64 : busy32), 64'd1);
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start32 = 1'b0;
            start64 = 1'b0;
            got = w64 ? done64 : done32;
            if (!got && lat == pulse_at) begin
                if (w64) begin a64 = 64'h7FF0000000000000; b64 = 64'h7FF0000000000000; start64 = 1'b1; end
                else begin a32 = 32'h7F800000; b32 = 32'h7F800000; start32 = 1'b1; end
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_out"}, w64 ? out64 : {32'd0, out32}, eo);
        chk({tag, "_flags"}, w64 ? {61'd0, ovf64, unf64, inv64} : {61'd0, ovf32, unf32, inv32}, {61'd0, ef});
        chk({tag, "_busy_done"}, 64'(w64 ? busy64 : busy32), 64'd0);
    endtask

    task automatic run_model(input bit w64, input logic [63:0] a, input logic [63:0] b, input string tag);
        logic [63:0] r;
        logic [2:0]  f;
        int          l;
        ref_mul(a, b, w64, r, f, l);
        run(w64, a, b, r, f, l, 0, tag);
    endtask

    function automatic logic [63:0] gen(input bit w64);
        int k = $urandom_range(0, 9);
        logic [63:0] m = {32'($urandom), 32'($urandom)};
        logic [31:0] r32;
        if (k == 0) begin
            case ($urandom_range(0, 3))
                0: r32 = 32'h00000000;
                1: r32 = 32'h7F800000;
                2: r32 = 32'h7FC00123;
                default: r32 = 32'h00000005;
            endcase
            if (w64) return {r32[31], {11{r32[30]}}, r32[22:0], 29'd0};
            return {32'd0, r32};
        end else if (k < 3) begin
            return w64 ? m : {32'd0, m[31:0]};
        end else if (w64) begin
            return {m[63], 11'(1023 + $urandom_range(0, 400) - 200), m[51:0]};
        end else begin
            return {32'd0, m[31], 8'(127 + $urandom_range(0, 60) - 30), m[22:0]};
        end
    endfunction

    initial begin
        bit seen = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_out32", {32'd0, out32}, 64'd0);
        chk("rst_flags32", {61'd0, ovf32, unf32, inv32}, 64'd0);
        chk("rst_out64", out64, 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        rst_n = 1'b1;

        run(0, 64'h40400000, 64'h40200000, 64'h40F00000, 3'b000, 26, 0, "mul_3x2p5");
        run(0, 64'h00000000, 64'h7F800000, 64'h7FC00000, 3'b001, 1, 0, "zero_x_inf");
        run(0, 64'h7FC00001, 64'h3F800000, 64'h7FC00000, 3'b001, 1, 0, "nan_in");
        run(0, 64'h7F000000, 64'h40000000, 64'h7F800000, 3'b100, 26, 0, "overflow");
        run(0, 64'h80800000, 64'h00800000, 64'h80000000, 3'b010, 26, 0, "underflow");
        run(0, 64'hFF800000, 64'h40000000, 64'hFF800000, 3'b000, 1, 0, "inf_in");
        run(0, 64'h80000001, 64'h40000000, 64'h80000000, 3'b000, 1, 0, "subnormal_in");
`ifdef FP_MUL_ROUND_EN
        run(0, 64'h3FC00001, 64'h3FC00001, 64'h40100002, 3'b000, 26, 0, "round");
`else
        run(0, 64'h3FC00001, 64'h3FC00001, 64'h40100001, 3'b000, 26, 0, "round");
`endif
        run(0, 64'h40400000, 64'h40200000, 64'h40F00000, 3'b000, 26, 5, "busy_start");

        // Abort an operation with reset partway through.
        @(negedge clk);
        a32 = 32'h40400000; b32 = 32'h40200000; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            start32 = (c == 5);
            if (c == 5) begin a32 = 32'h3F800000; b32 = 32'h3F800000; end
        end
        @(negedge clk);
        start32 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_out", {32'd0, out32}, 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run(0, 64'h40400000, 64'h40200000, 64'h40F00000, 3'b000, 26, 0, "rerun");

        run(1, 64'h4008000000000000, 64'h4004000000000000, 64'h401E000000000000, 3'b000, 55, 0, "mul64_3x2p5");
        run(1, 64'h0000000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 3'b001, 1, 0, "zero_x_inf64");

        for (int i = 0; i < 30; i++) run_model(0, gen(0), gen(0), "rand32");
        for (int i = 0; i < 8; i++) run_model(1, gen(1), gen(1), "rand64");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
